// File: rtl/uart_pkg.sv
// Shared UART constants: tx FSM state codes,
// oversampling ratio and stop-bit tick lengths.
package uart_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t START  = 3'd1;
  localparam state_t DATA   = 3'd2;
  localparam state_t STOP   = 3'd3;
  localparam state_t PARITY = 3'd4;

  localparam int OVERSAMPLE = 16;

  localparam int STOP_1   = 16;
  localparam int STOP_1P5 = 24;
  localparam int STOP_2   = 32;

endpackage

// File: rtl/uart_tx_fifo_drain_if.sv
// FIFO read port between the tx byte FIFO (slave)
// and the transmitter that drains it (master).
interface uart_tx_fifo_drain_if #(
  parameter int DBIT = 8
);

  logic            fifo_empty;
  logic [DBIT-1:0] fifo_r_data;
  logic            fifo_rd;

  modport master (
    input  fifo_empty,
    input  fifo_r_data,
    output fifo_rd
  );

  modport slave (
    output fifo_empty,
    output fifo_r_data,
    input  fifo_rd
  );

endinterface

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter draining the tx FIFO, paced by a 16x tick.
// Define UART_TX_PARITY_EN to add an even parity bit.
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = STOP_1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_tick,
  uart_tx_fifo_drain_if.master fifo,
  output logic                 tx,
  output logic                 tx_busy
);

  localparam logic [4:0] LAST_TICK = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DBIT - 1);

  state_t          state;
  logic [4:0]      tick_cnt;
  logic [2:0]      bit_cnt;
  logic [DBIT-1:0] shift_reg;
  logic            pop;
  logic            bit_end;

  assign pop     = (state == IDLE) & ~fifo.fifo_empty & ~reset;
  assign bit_end = s_tick & (tick_cnt == LAST_TICK);

  assign fifo.fifo_rd = pop;
  assign tx_busy      = (state != IDLE);

`ifdef UART_TX_PARITY_EN
  logic parity;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      parity <= 1'b0;
    else if (pop)
      parity <= ^fifo.fifo_r_data;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift_reg <= fifo.fifo_r_data;
            tick_cnt  <= '0;
            tx        <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= shift_reg[0];
            state    <= DATA;
          end else if (s_tick) begin
            tick_cnt <= tick_cnt + 5'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            tick_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              tx    <= parity;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              shift_reg <= shift_reg >> 1;
              bit_cnt   <= bit_cnt + 3'd1;
              tx        <= shift_reg[1];
            end
          end else if (s_tick) begin
            tick_cnt <= tick_cnt + 5'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            tick_cnt <= '0;
            tx       <= 1'b1;
            state    <= STOP;
          end else if (s_tick) begin
            tick_cnt <= tick_cnt + 5'd1;
          end
        end
`endif
        STOP: begin
          // Stop length is SB_TICK, not a full 16-tick bit
          if (s_tick && tick_cnt == STOP_LAST) begin
            tick_cnt <= '0;
            state    <= IDLE;
          end else if (s_tick) begin
            tick_cnt <= tick_cnt + 5'd1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench: two transmitters (1 and 2 stop bits) checked by
// a tick-counting UART receiver model and a FIFO model.
`timescale 1ns/1ps
module tb_uart_tx_fifo_drain;
  import uart_pkg::*;

  localparam int DBIT = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NB = DBIT + 2;
`else
  localparam int NB = DBIT + 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic s_tick = 1'b0;
  logic tick_all = 1'b1;
  int n_run = 0;
  int n_fail = 0;

  uart_tx_fifo_drain_if #(.DBIT(DBIT)) f0 ();
  uart_tx_fifo_drain_if #(.DBIT(DBIT)) f1 ();
  logic tx0, tx1, busy0, busy1;

  uart_tx_fifo_drain #(
    .DBIT(DBIT), .SB_TICK(STOP_1)
  ) u_dut0 (
    .clk(clk), .reset(reset), .s_tick(s_tick),
    .fifo(f0.master), .tx(tx0), .tx_busy(busy0)
  );

  uart_tx_fifo_drain #(
    .DBIT(DBIT), .SB_TICK(STOP_2)
  ) u_dut1 (
    .clk(clk), .reset(reset), .s_tick(s_tick),
    .fifo(f1.master), .tx(tx1), .tx_busy(busy1)
  );

  always #5 clk = ~clk;

  // FIFO models
  logic [7:0] fmem [2][256];
  int wp [2] = '{0, 0};
  int rp [2] = '{0, 0};

  assign f0.fifo_empty  = (wp[0] == rp[0]);
  assign f1.fifo_empty  = (wp[1] == rp[1]);
  assign f0.fifo_r_data = fmem[0][rp[0][7:0]];
  assign f1.fifo_r_data = fmem[1][rp[1][7:0]];

  always @(posedge clk) begin
    if (f0.fifo_rd) rp[0] <= rp[0] + 1;
    if (f1.fifo_rd) rp[1] <= rp[1] + 1;
  end

  logic txw [2], bsw [2], rdw [2], emw [2];
  assign txw[0] = tx0;
  assign txw[1] = tx1;
  assign bsw[0] = busy0;
  assign bsw[1] = busy1;
  assign rdw[0] = f0.fifo_rd;
  assign rdw[1] = f1.fifo_rd;
  assign emw[0] = f0.fifo_empty;
  assign emw[1] = f1.fifo_empty;

  int sbt [2] = '{STOP_1, STOP_2};

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] b,
                                   input int i);
    if (i == 0) return 1'b0;
    if (i <= DBIT) return b[i-1];
    return ^b;
  endfunction

  // Receiver model: k counts ticks consumed since the
  // start-bit fall; bit i is sampled at tick 16*i+8.
  logic prv_tx [2], prv_rd [2], pend [2];
  logic in_fr [2], exp_fall [2];
  logic [7:0] byt [2];
  int k [2];
  int npop [2] = '{0, 0};
  int nfrm [2] = '{0, 0};
  int nabt [2] = '{0, 0};

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (reset) begin
        if (in_fr[c] === 1'b1) nabt[c]++;
        in_fr[c] = 1'b0;
        pend[c] = 1'b0;
        prv_tx[c] = 1'b1;
        prv_rd[c] = 1'b0;
        exp_fall[c] = 1'b0;
      end else begin
        if (in_fr[c]) begin
          if (pend[c]) begin
            k[c]++;
            if (k[c] % 16 == 8 && k[c] < 16 * NB) begin
              check("bit", txw[c],
                    exp_bit(byt[c], k[c] / 16));
              check("busy_in_frame", bsw[c], 1);
            end
            if (k[c] == 16 * NB + 8)
              check("stop_bit", txw[c], 1);
          end
          if (txw[c] !== prv_tx[c])
            check("edge_align",
                  k[c] % 16 == 0 && k[c] <= 16 * NB, 1);
          if (k[c] == 16 * NB + sbt[c]) begin
            check("end_tx", txw[c], 1);
            check("end_busy", bsw[c], 0);
            in_fr[c] = 1'b0;
            nfrm[c]++;
            exp_fall[c] = (wp[c] != rp[c]);
          end
        end else begin
          if (exp_fall[c])
            check("b2b_start", txw[c], 0);
          exp_fall[c] = 1'b0;
          if (txw[c] === 1'b0 && prv_tx[c] === 1'b1) begin
            check("fall_on_pop", prv_rd[c], 1);
            in_fr[c] = 1'b1;
            k[c] = 0;
          end
        end
        if (rdw[c]) begin
          check("rd_nonempty", emw[c], 0);
          check("rd_not_adjacent", prv_rd[c], 0);
          byt[c] = fmem[c][rp[c][7:0]];
          npop[c]++;
        end
        prv_rd[c] = rdw[c];
        prv_tx[c] = txw[c];
        pend[c] = s_tick;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      s_tick = tick_all | ($urandom_range(0, 2) == 0);
    end
  end

  task automatic push_both(input logic [7:0] b);
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      fmem[c][wp[c][7:0]] = b;
      wp[c]++;
    end
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while (n < max &&
           !(wp[0] == rp[0] && wp[1] == rp[1] &&
             !in_fr[0] && !in_fr[1] &&
             !busy0 && !busy1)) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", n < max, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    logic seen;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;

    repeat (200) @(posedge clk);
    @(negedge clk);
    check("idle_tx0", tx0, 1);
    check("idle_tx1", tx1, 1);
    check("idle_busy0", busy0, 0);
    check("idle_busy1", busy1, 0);
    check("idle_pops", npop[0] + npop[1], 0);

    push_both(8'hA5);
    wait_drain(2000);
    push_both(8'h01);
    push_both(8'hFF);
    push_both(8'h80);
    wait_drain(4000);
    push_both(8'h00);
    wait_drain(2000);
    push_both(8'h07);
    push_both(8'h03);
    wait_drain(4000);

    push_both(8'h3C);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      seen = f0.fifo_rd;
      n++;
    end
    check("rd_3c_timeout", seen, 1);
    repeat (1 + 64 + 8) @(posedge clk);
    #2;
    check("busy_bit3", busy0, 1);
    #1 reset = 1'b1;
    #1;
    check("async_tx0", tx0, 1);
    check("async_tx1", tx1, 1);
    check("async_busy0", busy0, 0);
    check("async_busy1", busy1, 0);
    @(posedge clk);
    #3 reset = 1'b0;
    push_both(8'h5A);
    wait_drain(2000);

    tick_all = 1'b0;
    for (int i = 0; i < 24; i++) begin
      push_both(8'($urandom));
      repeat ($urandom_range(0, 400)) @(posedge clk);
    end
    wait_drain(40000);

    for (int c = 0; c < 2; c++) begin
      check("pop_count", npop[c], wp[c]);
      check("frames", nfrm[c] + nabt[c], npop[c]);
      check("aborted", nabt[c], 1);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
